multicycle_controller: RTL and testbench

- Parametrised multi-cycle RV32I control unit; successor to the single-cycle controller.
- A Moore FSM sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction, with a ready handshake to a shared instruction/data memory.
- Adds the full branch set, LUI/AUIPC, the full ALU op set, and a sticky illegal-instruction trap.
- Sits in the multi-cycle datapath and drives PC/IR enables, the address mux, ALU operand muxes and register-file write.

---
 rtl/mc_pkg.sv | 85 ++++++++
 rtl/alu_decoder_rv32i.sv | 31 +++
 rtl/multicycle_controller.sv | 161 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package mc_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 7;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALU_MODE_ADD  = 2'd0,
    ALU_MODE_SUB  = 2'd1,
    ALU_MODE_FUNC = 2'd2
  } alu_mode_t;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

  // ALUControl codes are {arith, funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Branch condition from the comparator flags; unused funct3 codes never take
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic lt, input logic ltu);
    logic t;
    case (f3)
      3'b000:  t = zero;
      3'b001:  t = !zero;
      3'b100:  t = lt;
      3'b101:  t = !lt;
      3'b110:  t = ltu;
      3'b111:  t = !ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/alu_decoder_rv32i.sv
// Maps the FSM's ALU mode and instruction fields to an ALUControl code.
module alu_decoder_rv32i
  import mc_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4
) (
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  op5,
  input  alu_mode_t             mode,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic arith;

  // R-type takes funct7b5 always; I-type only for shifts, so addi never becomes SUB
  always_comb begin
    arith       = 1'b0;
    alu_control = ALU_CTRL_W'(ALU_ADD);
    case (mode)
      ALU_MODE_ADD: alu_control = ALU_CTRL_W'(ALU_ADD);
      ALU_MODE_SUB: alu_control = ALU_CTRL_W'(ALU_SUB);
      ALU_MODE_FUNC: begin
        arith       = op5 ? funct7b5 : ((funct3 == 3'b101) && funct7b5);
        alu_control = ALU_CTRL_W'({arith, funct3});
      end
      default: alu_control = ALU_CTRL_W'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes datapath strobes and mux selects from the current state.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W    = 4,
  parameter bit          EN_EXT_BRANCH = 1'b1,
  parameter bit          EN_UPPER_IMM  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  Zero,
  input  logic                  LT,
  input  logic                  LTU,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [2:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  RegWrite,
  output logic                  illegal,
  output logic [3:0]            state_dbg
);

  state_t    state, state_next;
  alu_mode_t alu_mode;
  logic      branch_legal;

  assign branch_legal = (funct3 == 3'b000) ||
                        (EN_EXT_BRANCH && ((funct3 == 3'b001) || funct3[2]));
  assign state_dbg    = state;

  // State and sticky trap flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == S_TRAP) illegal <= 1'b1;
    end
  end

  // Next-state
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        state_next = S_TRAP;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         if (branch_legal) state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_LUI:            if (EN_UPPER_IMM) state_next = S_LUI;
          // auipc result (OldPC + immU) is already in ALUOut after decode
          OP_AUIPC:          if (EN_UPPER_IMM) state_next = S_ALUWB;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_EXECR,
      S_EXECI,
      S_JAL,
      S_LUI:      state_next = S_ALUWB;
      S_ALUWB,
      S_BRANCH:   state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase
  end

  // Moore output decode; defaults are all-zero strobes and selects
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ImmSrc    = IMM_I;
    alu_mode  = ALU_MODE_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_AUIPC) ? IMM_U : IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_READDATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA  = SRCA_RS1;
        alu_mode = ALU_MODE_FUNC;
      end
      S_EXECI: begin
        ALUSrcA  = SRCA_RS1;
        ALUSrcB  = SRCB_IMM;
        alu_mode = ALU_MODE_FUNC;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = SRCA_RS1;
        alu_mode = ALU_MODE_SUB;
        PCWrite  = branch_taken(funct3, Zero, LT, LTU);
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
      end
      default: ;
    endcase
  end

  alu_decoder_rv32i #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .mode        (alu_mode),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-instruction expected traces plus literal pins.
module tb_multicycle_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n, reset_n2;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, lt, ltu, mem_ready;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl, state_dbg;

  logic       PCWrite_b, AdrSrc_b, MemWrite_b, IRWrite_b, RegWrite_b, illegal_b;
  logic [1:0] ResultSrc_b, ALUSrcA_b, ALUSrcB_b;
  logic [2:0] ImmSrc_b;
  logic [3:0] ALUControl_b, state_dbg_b;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(zero), .LT(lt), .LTU(ltu), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .RegWrite(RegWrite), .illegal(illegal), .state_dbg(state_dbg)
  );

  multicycle_controller #(.EN_EXT_BRANCH(1'b0), .EN_UPPER_IMM(1'b0)) dut_nb (
    .clk(clk), .reset_n(reset_n2), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(zero), .LT(lt), .LTU(ltu), .mem_ready(mem_ready),
    .PCWrite(PCWrite_b), .AdrSrc(AdrSrc_b), .MemWrite(MemWrite_b), .IRWrite(IRWrite_b),
    .ResultSrc(ResultSrc_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .ImmSrc(ImmSrc_b),
    .ALUControl(ALUControl_b), .RegWrite(RegWrite_b), .illegal(illegal_b),
    .state_dbg(state_dbg_b)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       rw;
    logic       ill;
  } obs_t;

  int checks, passes, cyc_cnt, rw_cnt, memw_cnt;
  logic [3:0] last_exec_alu;
  logic       last_br_pcw;

  // ---------------- model ----------------
  function automatic obs_t rec(input logic [3:0] st);
    obs_t r;
    r = '0;
    r.st = st;
    return r;
  endfunction

  function automatic obs_t f_fetch(input logic mr);
    obs_t r;
    r = rec(S_FETCH);
    r.sb = 2'b10; r.rs = 2'b10; r.irw = mr; r.pcw = mr;
    return r;
  endfunction

  function automatic logic [3:0] alu_model(input logic r_type, input logic [2:0] f3,
                                           input logic f7);
    logic arith;
    if (r_type) arith = f7;
    else        arith = (f3 == 3'b101) ? f7 : 1'b0;
    return {arith, f3};
  endfunction

  function automatic logic br_model(input logic [2:0] f3, input logic z, input logic l,
                                    input logic lu);
    if (f3 == 3'b000) return z;
    if (f3 == 3'b001) return !z;
    if (f3 == 3'b100) return l;
    if (f3 == 3'b101) return !l;
    if (f3 == 3'b110) return lu;
    return !lu;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.st = state_dbg; a.pcw = PCWrite; a.adr = AdrSrc; a.memw = MemWrite; a.irw = IRWrite;
    a.rs = ResultSrc; a.sa = ALUSrcA; a.sb = ALUSrcB; a.imm = ImmSrc; a.alu = ALUControl;
    a.rw = RegWrite; a.ill = illegal;
    return a;
  endfunction

  // One clock: drive inputs after the edge, compare at the falling edge
  task automatic cyc(input obs_t e, input logic mr, input logic rn = 1'b1);
    obs_t a;
    @(posedge clk); #1;
    reset_n = rn; reset_n2 = 1'b1; mem_ready = mr;
    @(negedge clk);
    a = sample();
    cyc_cnt++;
    if (RegWrite) rw_cnt++;
    if (MemWrite) memw_cnt++;
    if (state_dbg == S_EXECR || state_dbg == S_EXECI) last_exec_alu = ALUControl;
    if (state_dbg == S_BRANCH) last_br_pcw = PCWrite;
    checks++;
    if (a === e) passes++;
    else $display("FAIL cycle_%0d outputs: got %h required %h (st got %0d req %0d)",
                  cyc_cnt, a, e, a.st, e.st);
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++) cyc(f_fetch(1'b0), 1'b0);
    cyc(f_fetch(1'b1), 1'b1);
  endtask

  task automatic decode(input logic au);
    obs_t r;
    r = rec(S_DECODE);
    r.sa = 2'b01; r.sb = 2'b01; r.imm = au ? 3'b100 : 3'b010;
    cyc(r, 1'b1);
  endtask

  task automatic aluwb();
    obs_t r;
    r = rec(S_ALUWB);
    r.rw = 1'b1;
    cyc(r, 1'b1);
  endtask

  task automatic do_alu(input logic r_type, input logic [2:0] f3, input logic f7);
    obs_t r;
    set_ir(r_type ? 7'h33 : 7'h13, f3, f7);
    fetch(0);
    decode(1'b0);
    r = rec(r_type ? S_EXECR : S_EXECI);
    r.sa = 2'b10; r.sb = r_type ? 2'b00 : 2'b01; r.alu = alu_model(r_type, f3, f7);
    cyc(r, 1'b1);
    aluwb();
  endtask

  task automatic do_lw(input int fw, input int mw, input logic abort);
    obs_t r;
    set_ir(7'h03, 3'b010, 1'b0);
    fetch(fw);
    decode(1'b0);
    r = rec(S_MEMADR);
    r.sa = 2'b10; r.sb = 2'b01; r.imm = 3'b000;
    cyc(r, 1'b1);
    r = rec(S_MEMREAD);
    r.adr = 1'b1;
    for (int i = 0; i < mw; i++) cyc(r, 1'b0);
    if (abort) begin
      cyc(r, 1'b0, 1'b0);
    end else begin
      cyc(r, 1'b1);
      r = rec(S_MEMWB);
      r.rs = 2'b01; r.rw = 1'b1;
      cyc(r, 1'b1);
    end
  endtask

  task automatic do_sw(input int mw);
    obs_t r;
    set_ir(7'h23, 3'b010, 1'b0);
    fetch(0);
    decode(1'b0);
    r = rec(S_MEMADR);
    r.sa = 2'b10; r.sb = 2'b01; r.imm = 3'b001;
    cyc(r, 1'b1);
    r = rec(S_MEMWRITE);
    r.adr = 1'b1; r.memw = 1'b1;
    for (int i = 0; i < mw; i++) cyc(r, 1'b0);
    cyc(r, 1'b1);
  endtask

  task automatic do_branch(input logic [2:0] f3, input logic z, input logic l, input logic lu);
    obs_t r;
    set_ir(7'h63, f3, 1'b0);
    zero = z; lt = l; ltu = lu;
    fetch(0);
    decode(1'b0);
    r = rec(S_BRANCH);
    r.sa = 2'b10; r.sb = 2'b00; r.alu = 4'b1000; r.pcw = br_model(f3, z, l, lu);
    cyc(r, 1'b1);
  endtask

  task automatic do_jal();
    obs_t r;
    set_ir(7'h6F, 3'b000, 1'b0);
    fetch(0);
    decode(1'b0);
    r = rec(S_JAL);
    r.sa = 2'b01; r.sb = 2'b10; r.pcw = 1'b1;
    cyc(r, 1'b1);
    aluwb();
  endtask

  task automatic do_lui();
    obs_t r;
    set_ir(7'h37, 3'b000, 1'b0);
    fetch(0);
    decode(1'b0);
    r = rec(S_LUI);
    r.sa = 2'b11; r.sb = 2'b01; r.imm = 3'b100;
    cyc(r, 1'b1);
    aluwb();
  endtask

  task automatic do_auipc();
    set_ir(7'h17, 3'b000, 1'b0);
    fetch(0);
    decode(1'b1);
    aluwb();
  endtask

  // Illegal instruction: sits in TRAP, then a one-edge reset returns to FETCH
  task automatic do_trap(input logic [6:0] o, input logic [2:0] f3, input string name);
    obs_t t;
    set_ir(o, f3, 1'b0);
    fetch(0);
    decode(1'b0);
    t = rec(S_TRAP);
    t.ill = 1'b1;
    cyc(t, 1'b1);
    cyc(t, 1'b1);
    lit({name, "_illegal_held"}, illegal, 1);
    cyc(t, 1'b1, 1'b0);
    cyc(f_fetch(1'b0), 1'b0);
    lit({name, "_reset_state"}, state_dbg, 0);
    lit({name, "_reset_illegal"}, illegal, 0);
  endtask

  int c0, r0, m0;

  initial begin
    checks = 0; passes = 0; cyc_cnt = 0; rw_cnt = 0; memw_cnt = 0;
    last_exec_alu = '0; last_br_pcw = 1'b0;
    op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    mem_ready = 1'b0; reset_n = 1'b0; reset_n2 = 1'b0;

    cyc(f_fetch(1'b0), 1'b0, 1'b0);
    lit("reset_state", state_dbg, 0);
    lit("reset_illegal", illegal, 0);

    c0 = cyc_cnt; r0 = rw_cnt;
    do_alu(1'b1, 3'b000, 1'b0);
    lit("add_cycles", cyc_cnt - c0, 4);
    lit("add_alu", last_exec_alu, 0);
    lit("add_regwrite", rw_cnt - r0, 1);

    c0 = cyc_cnt; r0 = rw_cnt;
    do_lw(2, 1, 1'b0);
    lit("lw_cycles", cyc_cnt - c0, 8);
    lit("lw_regwrite", rw_cnt - r0, 1);

    c0 = cyc_cnt; r0 = rw_cnt; m0 = memw_cnt;
    do_sw(1);
    lit("sw_cycles", cyc_cnt - c0, 5);
    lit("sw_memwrite", memw_cnt - m0, 2);
    lit("sw_regwrite", rw_cnt - r0, 0);

    do_alu(1'b0, 3'b000, 1'b1);  lit("addi_f7_alu", last_exec_alu, 4'b0000);
    do_alu(1'b0, 3'b101, 1'b1);  lit("srai_alu", last_exec_alu, 4'b1101);
    do_alu(1'b0, 3'b101, 1'b0);  lit("srli_alu", last_exec_alu, 4'b0101);
    do_alu(1'b1, 3'b000, 1'b1);  lit("sub_alu", last_exec_alu, 4'b1000);
    do_alu(1'b1, 3'b101, 1'b1);  lit("sra_alu", last_exec_alu, 4'b1101);
    do_alu(1'b0, 3'b100, 1'b0);  lit("xori_alu", last_exec_alu, 4'b0100);
    do_alu(1'b1, 3'b011, 1'b0);  lit("sltu_alu", last_exec_alu, 4'b0011);
    do_alu(1'b1, 3'b111, 1'b0);  lit("and_alu", last_exec_alu, 4'b0111);

    do_branch(3'b001, 1'b1, 1'b0, 1'b0);  lit("bne_z1_pcw", last_br_pcw, 0);
    do_branch(3'b000, 1'b1, 1'b0, 1'b0);  lit("beq_z1_pcw", last_br_pcw, 1);
    do_branch(3'b110, 1'b0, 1'b0, 1'b1);  lit("bltu_pcw", last_br_pcw, 1);
    do_branch(3'b101, 1'b0, 1'b1, 1'b0);  lit("bge_lt1_pcw", last_br_pcw, 0);
    do_branch(3'b111, 1'b0, 1'b0, 1'b0);  lit("bgeu_pcw", last_br_pcw, 1);

    // Restart the no-extension instance so both start blt from FETCH
    reset_n2 = 1'b0;
    do_branch(3'b100, 1'b0, 1'b1, 1'b0);
    lit("blt_ext_pcw", last_br_pcw, 1);
    lit("blt_noext_state", state_dbg_b, 12);
    lit("blt_noext_illegal", illegal_b, 1);
    lit("blt_noext_strobes", {PCWrite_b, MemWrite_b, IRWrite_b, RegWrite_b}, 0);
    lit("blt_noext_selects",
        {AdrSrc_b, ResultSrc_b, ALUSrcA_b, ALUSrcB_b, ImmSrc_b, ALUControl_b}, 0);

    c0 = cyc_cnt; r0 = rw_cnt;
    do_jal();
    lit("jal_cycles", cyc_cnt - c0, 4);
    lit("jal_regwrite", rw_cnt - r0, 1);
    do_lui();
    c0 = cyc_cnt;
    do_auipc();
    lit("auipc_cycles", cyc_cnt - c0, 3);

    r0 = rw_cnt;
    do_lw(0, 1, 1'b1);
    cyc(f_fetch(1'b0), 1'b0);
    lit("lw_abort_state", state_dbg, 0);
    lit("lw_abort_regwrite", rw_cnt - r0, 0);

    do_trap(7'h7F, 3'b000, "op7f");
    do_trap(7'h63, 3'b010, "br010");

    do_alu(1'b1, 3'b110, 1'b0);  lit("or_after_reset_alu", last_exec_alu, 4'b0110);
    lit("noext_illegal_sticky", illegal_b, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
